// File: rtl/wfg_stim_ramp_top_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wfg_stim_ramp_wb_if / wfg_stim_ramp_axis_if
// Description : Bus bundles for the ramp stimulus source.
//               wfg_stim_ramp_wb_if   - Wishbone classic slave page
//                 (stb, cyc, we, sel, adr, dat in / ack, dat out)
//               wfg_stim_ramp_axis_if - AXI-Stream sample link
//                 (tvalid, tdata forward / tready backward)
//               The master modport belongs to the side that starts the
//               transfer: the bus host for Wishbone, the ramp for AXIS.
// Revision    : 1.0 - initial release
// ============================================================================

interface wfg_stim_ramp_wb_if #(
  parameter int unsigned BUSW = 32
);
  logic            wbs_stb_i;
  logic            wbs_cyc_i;
  logic            wbs_we_i;
  logic [3:0]      wbs_sel_i;
  logic [BUSW-1:0] wbs_dat_i;
  logic [BUSW-1:0] wbs_adr_i;
  logic            wbs_ack_o;
  logic [BUSW-1:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

interface wfg_stim_ramp_axis_if #(
  parameter int unsigned BUSW = 32
);
  logic            wfg_axis_tready_i;
  logic            wfg_axis_tvalid_o;
  logic [BUSW-1:0] wfg_axis_tdata_o;

  modport master (
    input  wfg_axis_tready_i,
    output wfg_axis_tvalid_o, wfg_axis_tdata_o
  );

  modport slave (
    output wfg_axis_tready_i,
    input  wfg_axis_tvalid_o, wfg_axis_tdata_o
  );
endinterface

`default_nettype wire

// File: rtl/wfg_stim_ramp_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wfg_stim_ramp_top
// Description : Wishbone-configured sawtooth / triangle ramp source driving
//               a 32-bit AXI-Stream stimulus slot.
// Ports       : wb_clk_i  - clock, rising edge
//               wb_rst_ni - asynchronous active-low reset
//               wb        - Wishbone slave page (CTRL/START/STOP/INC)
//               axis      - AXI-Stream master (tvalid/tdata out, tready in)
// Registers   : 0x0 CTRL  bit0 EN, bit1 MODE (0 saw, 1 triangle)
//               0x4 START, 0x8 STOP, 0xC INC[15:0]
// Revision    : 1.0 - initial release
// ============================================================================

module wfg_stim_ramp_top #(
  parameter int unsigned BUSW = 32
) (
  input  wire logic              wb_clk_i,
  input  wire logic              wb_rst_ni,
  wfg_stim_ramp_wb_if.slave      wb,
  wfg_stim_ramp_axis_if.master   axis
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Register file and Wishbone slave
  // --------------------------------------------------------------------------
  logic            r_ack;
  logic [BUSW-1:0] r_rdat;
  logic            r_en;
  logic            r_mode;
  logic [BUSW-1:0] r_start;
  logic [BUSW-1:0] r_stop;
  logic [15:0]     r_inc;

  logic            w_access;
  logic            w_wr;
  logic            w_rd;
  logic [BUSW-1:0] w_rd_mux;
  logic            w_unused;

  // Gating with ~r_ack makes a held strobe acknowledge every other cycle.
  assign w_access = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack;
  assign w_wr     = w_access &  wb.wbs_we_i;
  assign w_rd     = w_access & ~wb.wbs_we_i;

  // Byte selects and the non-decoded address bits have no effect.
  assign w_unused = ^{wb.wbs_sel_i, wb.wbs_adr_i[BUSW-1:4], wb.wbs_adr_i[1:0]};

  always_comb begin
    w_rd_mux = '0;
    case (wb.wbs_adr_i[3:2])
      2'd0:    w_rd_mux[1:0]  = {r_mode, r_en};
      2'd1:    w_rd_mux       = r_start;
      2'd2:    w_rd_mux       = r_stop;
      default: w_rd_mux[15:0] = r_inc;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack   <= 1'b0;
      r_rdat  <= '0;
      r_en    <= 1'b0;
      r_mode  <= 1'b0;
      r_start <= '0;
      r_stop  <= '0;
      r_inc   <= 16'd1;
    end else begin
      r_ack  <= w_access;
      // Read data is only driven during the ack cycle, zero otherwise.
      r_rdat <= w_rd ? w_rd_mux : '0;
      if (w_wr) begin
        case (wb.wbs_adr_i[3:2])
          2'd0: begin
            r_en   <= wb.wbs_dat_i[0];
            r_mode <= wb.wbs_dat_i[1];
          end
          2'd1:    r_start <= wb.wbs_dat_i;
          2'd2:    r_stop  <= wb.wbs_dat_i;
          default: r_inc   <= wb.wbs_dat_i[15:0];
        endcase
      end
    end
  end

  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_rdat;

  // --------------------------------------------------------------------------
  // Ramp datapath
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [BUSW-1:0] r_tdata;
  logic            r_tvalid;

  state_t          w_state_nxt;
  logic [BUSW-1:0] w_tdata_nxt;
  logic            w_tvalid_nxt;

  logic [BUSW-1:0] w_inc_eff;
  logic [BUSW:0]   w_sum;
  logic [BUSW:0]   w_dif;
  logic            w_degen;
  logic            w_hs;

  // A zero step would freeze the ramp, so the datapath uses 1 instead.
  assign w_inc_eff = (r_inc == 16'd0) ? {{(BUSW-1){1'b0}}, 1'b1}
                                      : {{(BUSW-16){1'b0}}, r_inc};

  // One extra bit catches carry out of the top and borrow below zero.
  assign w_sum   = {1'b0, r_tdata} + {1'b0, w_inc_eff};
  assign w_dif   = {1'b0, r_tdata} - {1'b0, w_inc_eff};
  assign w_degen = (r_start >= r_stop);
  assign w_hs    = r_tvalid & axis.wfg_axis_tready_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    case (r_state)
      ST_IDLE: begin
        w_tvalid_nxt = 1'b0;
        if (r_en) begin
          w_tdata_nxt  = r_start;
          w_tvalid_nxt = 1'b1;
          w_state_nxt  = ST_UP;
        end
      end
      ST_UP, ST_DOWN: begin
        if (!r_en && !r_tvalid) begin
          w_tvalid_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else if (w_hs) begin
          if (!r_en) begin
            // Disable takes effect only once the pending beat has moved.
            w_tvalid_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
          end else if (w_degen) begin
            // Empty range: pin the output to START in either mode.
            w_tdata_nxt = r_start;
            w_state_nxt = ST_UP;
          end else if (r_state == ST_UP) begin
            if (w_sum[BUSW] || (w_sum[BUSW-1:0] >= r_stop)) begin
              if (r_mode) begin
                w_tdata_nxt = r_stop;
                w_state_nxt = ST_DOWN;
              end else begin
                w_tdata_nxt = r_start;
              end
            end else begin
              w_tdata_nxt = w_sum[BUSW-1:0];
            end
          end else begin
            if (w_dif[BUSW] || (w_dif[BUSW-1:0] <= r_start)) begin
              w_tdata_nxt = r_start;
              w_state_nxt = ST_UP;
            end else begin
              w_tdata_nxt = w_dif[BUSW-1:0];
            end
          end
        end
      end
      default: begin
        w_tvalid_nxt = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= ST_IDLE;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
    end
  end

  assign axis.wfg_axis_tvalid_o = r_tvalid;
  assign axis.wfg_axis_tdata_o  = r_tdata;

endmodule

`default_nettype wire

// File: tb/tb_wfg_stim_ramp_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_wfg_stim_ramp_top
// Description : Self-checking bench for wfg_stim_ramp_top. A sample-level
//               model predicts tvalid/tdata every cycle; directed sequences
//               with literal expected values pin the model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_wfg_stim_ramp_top;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wfg_stim_ramp_wb_if   #(.BUSW(32)) wb ();
  wfg_stim_ramp_axis_if #(.BUSW(32)) ax ();

  wfg_stim_ramp_top #(.BUSW(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb        (wb),
    .axis      (ax)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench copy of the configuration, updated when a write is acknowledged.
  logic        sh_en    = 1'b0;
  logic        sh_mode  = 1'b0;
  logic [31:0] sh_start = '0;
  logic [31:0] sh_stop  = '0;
  logic [15:0] sh_inc   = 16'd1;

  // Next sample from the ramp rules; returns {direction_up, value}.
  function automatic logic [32:0] next_sample(input logic [31:0] cur, input logic up);
    longint s, p, i, n;
    s = longint'(sh_start);
    p = longint'(sh_stop);
    i = (sh_inc == 16'd0) ? 64'sd1 : longint'(sh_inc);
    if (s >= p) return {1'b1, sh_start};
    if (up) begin
      n = longint'(cur) + i;
      if (n >= p) return sh_mode ? {1'b0, sh_stop} : {1'b1, sh_start};
      return {1'b1, n[31:0]};
    end
    n = longint'(cur) - i;
    if (n <= s) return {1'b1, sh_start};
    return {1'b0, n[31:0]};
  endfunction

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_up;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_up    <= 1'b1;
    end else if (!m_valid) begin
      if (sh_en) begin
        m_valid <= 1'b1;
        m_data  <= sh_start;
        m_up    <= 1'b1;
      end
    end else if (ax.wfg_axis_tready_i) begin
      if (!sh_en) m_valid <= 1'b0;
      else {m_up, m_data} <= next_sample(m_data, m_up);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_tvalid", 32'(ax.wfg_axis_tvalid_o), 32'(m_valid));
      if (m_valid) check("model_tdata", ax.wfg_axis_tdata_o, m_data);
    end
  end

  logic [31:0] capq[$];
  always @(posedge clk) begin
    if (rst_n && ax.wfg_axis_tvalid_o && ax.wfg_axis_tready_i)
      capq.push_back(ax.wfg_axis_tdata_o);
  end

  task automatic check_seq(input string name, input logic [31:0] exp[$]);
    int n;
    n = 0;
    while (capq.size() < exp.size() && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (capq.size() < exp.size()) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", name, capq.size(), exp.size());
    end else begin
      foreach (exp[k]) check($sformatf("%s[%0d]", name, k), capq[k], exp[k]);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input bit lat_chk = 1'b0, input logic [31:0] first = '0);
    int n;
    n = 0;
    @(negedge clk);
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb.wbs_ack_o && n < 4);
    check("wr_ack_latency", 32'(n), 32'd1);
    if (wb.wbs_ack_o) begin
      case (adr[3:2])
        2'd0: begin
          sh_en   = dat[0];
          sh_mode = dat[1];
        end
        2'd1:    sh_start = dat;
        2'd2:    sh_stop  = dat;
        default: sh_inc   = dat[15:0];
      endcase
    end
    if (lat_chk) check("en_latency_pre", 32'(ax.wfg_axis_tvalid_o), 32'd0);
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk);
    #1;
    check("wr_ack_single", 32'(wb.wbs_ack_o), 32'd0);
    if (lat_chk) begin
      check("en_latency_valid", 32'(ax.wfg_axis_tvalid_o), 32'd1);
      check("en_latency_data", ax.wfg_axis_tdata_o, first);
    end
  endtask

  task automatic wb_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    wb.wbs_adr_i = adr;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb.wbs_ack_o && n < 4);
    check("rd_ack_latency", 32'(n), 32'd1);
    check(name, wb.wbs_dat_o, exp);
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    @(posedge clk);
    #1;
    check("rd_ack_single", 32'(wb.wbs_ack_o), 32'd0);
  endtask

  task automatic stop_stream();
    ax.wfg_axis_tready_i = 1'b1;
    wb_write(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("stopped_tvalid", 32'(ax.wfg_axis_tvalid_o), 32'd0);
    capq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp[$];
    bit          pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    ax.wfg_axis_tready_i = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_tvalid", 32'(ax.wfg_axis_tvalid_o), 32'd0);
    check("rst_tdata", ax.wfg_axis_tdata_o, 32'd0);
    check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    wb_read("rst_ctrl", 32'h0, 32'h0);
    wb_read("rst_start", 32'h4, 32'h0);
    wb_read("rst_stop", 32'h8, 32'h0);
    wb_read("rst_inc", 32'hC, 32'h1);

    // Register read-back
    wb_write(32'h4, 32'h1234_5678);
    wb_read("rb_start", 32'h4, 32'h1234_5678);
    wb_write(32'h8, 32'h8765_4321);
    wb_read("rb_stop", 32'h8, 32'h8765_4321);
    wb_write(32'hC, 32'hABCD_1234);
    wb_read("rb_inc", 32'hC, 32'h0000_1234);
    wb_write(32'h0, 32'hFFFF_FFFC);
    wb_read("rb_ctrl", 32'h0, 32'h0);

    // Held strobe: ack on every other cycle
    @(negedge clk);
    wb.wbs_adr_i = 32'h4;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b_ack[%0d]", k), 32'(wb.wbs_ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    repeat (2) @(posedge clk);

    // Sawtooth 0..3
    wb_write(32'h4, 32'd0);
    wb_write(32'h8, 32'd4);
    wb_write(32'hC, 32'd1);
    capq.delete();
    wb_write(32'h0, 32'h1, 1'b1, 32'd0);
    exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3};
    check_seq("saw", exp);
    stop_stream();

    // Sawtooth under backpressure
    wb_write(32'h0, 32'h1);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      ax.wfg_axis_tready_i = pat[k % 4];
    end
    ax.wfg_axis_tready_i = 1'b1;
    exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3};
    check_seq("bp_saw", exp);
    stop_stream();

    // Triangle 10..16 step 3, then a live STOP change
    wb_write(32'h4, 32'd10);
    wb_write(32'h8, 32'd16);
    wb_write(32'hC, 32'd3);
    wb_write(32'h0, 32'h3);
    exp = '{32'd10, 32'd13, 32'd16, 32'd13, 32'd10, 32'd13, 32'd16};
    check_seq("tri", exp);
    wb_write(32'h8, 32'd22);
    repeat (12) @(posedge clk);
    stop_stream();

    // Overflow near the top of the range
    wb_write(32'h4, 32'hFFFF_FFF0);
    wb_write(32'h8, 32'hFFFF_FFFF);
    wb_write(32'hC, 32'h10);
    wb_write(32'h0, 32'h1);
    exp = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    check_seq("ovf_saw", exp);
    stop_stream();
    wb_write(32'h0, 32'h3);
    exp = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    check_seq("ovf_tri", exp);
    stop_stream();

    // INC=0 steps by one
    wb_write(32'hC, 32'h0);
    wb_read("rb_inc0", 32'hC, 32'h0);
    wb_write(32'h4, 32'd5);
    wb_write(32'h8, 32'd8);
    wb_write(32'h0, 32'h1);
    exp = '{32'd5, 32'd6, 32'd7, 32'd5, 32'd6};
    check_seq("inc0", exp);
    stop_stream();

    // Degenerate ranges give constant START
    wb_write(32'h4, 32'd9);
    wb_write(32'h8, 32'd9);
    wb_write(32'h0, 32'h3);
    exp = '{32'd9, 32'd9, 32'd9, 32'd9};
    check_seq("degen_eq", exp);
    stop_stream();
    wb_write(32'h4, 32'd20);
    wb_write(32'h0, 32'h1);
    exp = '{32'd20, 32'd20, 32'd20};
    check_seq("degen_gt", exp);
    stop_stream();

    // Disable while the sink stalls, then re-enable as triangle
    wb_write(32'h4, 32'd0);
    wb_write(32'h8, 32'd4);
    wb_write(32'hC, 32'd1);
    wb_write(32'h0, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ax.wfg_axis_tready_i = 1'b0;
    wb_write(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("dis_hold_tvalid", 32'(ax.wfg_axis_tvalid_o), 32'd1);
    @(negedge clk);
    ax.wfg_axis_tready_i = 1'b1;
    @(posedge clk);
    #1;
    check("dis_fall_tvalid", 32'(ax.wfg_axis_tvalid_o), 32'd0);
    capq.delete();
    wb_write(32'h0, 32'h3, 1'b1, 32'd0);
    exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 32'd2};
    check_seq("reen_tri", exp);

    // Asynchronous reset mid-stream
    repeat (3) @(posedge clk);
    #3;
    rst_n    = 1'b0;
    sh_en    = 1'b0;
    sh_mode  = 1'b0;
    sh_start = '0;
    sh_stop  = '0;
    sh_inc   = 16'd1;
    #1;
    check("arst_tvalid", 32'(ax.wfg_axis_tvalid_o), 32'd0);
    check("arst_tdata", ax.wfg_axis_tdata_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_read("arst_ctrl", 32'h0, 32'h0);
    wb_read("arst_inc", 32'hC, 32'h1);
    wb_read("arst_start", 32'h4, 32'h0);
    wb_read("arst_stop", 32'h8, 32'h0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
